matinv_rr_sched: RTL and testbench

//  Shares one 2x2 Q2.14 matrix_inv pipeline (fixed LAT-cycle latency) among N_REQ requesters.
//  - Round-robin arbitration over the request ports; at most one issue per cycle.
//  - Each issued operation carries a requester tag through a latency-matched shift register,
//    so every result and error flag is steered back to its requester.
//  - A hold/drain control quiesces the unit, for example before a reset or reconfiguration.

---
 rtl/matinv_rr_sched.sv | 150 +++++++++++++++
 tb/tb_matinv_rr_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matinv_rr_sched.sv
// Round-robin front end that shares one fixed-latency 2x2 matrix_inv pipeline among
// N_REQ requesters; a tag shift register steers each result back to its requester.
module matinv_rr_sched #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned LAT   = 3,
   parameter int unsigned DW    = 16,
   parameter int unsigned IDW   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*4*DW-1:0]   req_mat,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    hold,
   output logic [DW-1:0]           mi_a,
   output logic [DW-1:0]           mi_b,
   output logic [DW-1:0]           mi_c,
   output logic [DW-1:0]           mi_d,
   input  logic [DW-1:0]           mi_a_inv,
   input  logic [DW-1:0]           mi_b_inv,
   input  logic [DW-1:0]           mi_c_inv,
   input  logic [DW-1:0]           mi_d_inv,
   input  logic                    mi_error,
   output logic [N_REQ-1:0]        resp_valid,
   output logic [4*DW-1:0]         resp_mat,
   output logic                    resp_err,
   output logic [2:0]              inflight,
   output logic                    idle,
   output logic [7:0]              err_cnt
);
   localparam int unsigned MW = 4 * DW;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HELD} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [MW-1:0]    opnd_q, opnd_d;
   logic [LAT-1:0]   tag_v_q, tag_v_d;
   logic [IDW-1:0]   tag_id_q [LAT];
   logic [IDW-1:0]   tag_id_d [LAT];
   logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
   logic [2:0]       inflight_q, inflight_d;
   logic             idle_q, idle_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic             grant_found;
   logic [IDW-1:0]   grant_id;
   logic [N_REQ-1:0] grant;
   logic [MW-1:0]    grant_mat;
   int unsigned      scan;
   logic [IDW-1:0]   scan_id;
   logic             resp_any;

   // Round-robin search from ptr upward with wrap at N_REQ-1; only in RUN
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      grant       = '0;
      grant_mat   = '0;
      scan        = 0;
      scan_id     = '0;
      if (state_q == ST_RUN) begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = 32'(ptr_q) + k;
            if (scan >= N_REQ) scan = scan - N_REQ;
            scan_id = IDW'(scan);
            if (!grant_found && req_valid[scan_id]) begin
               grant_found = 1'b1;
               grant_id    = scan_id;
            end
         end
      end
      if (grant_found) grant[grant_id] = 1'b1;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) grant_mat = req_mat[i*MW +: MW];
      end
   end

   assign req_ready = grant;
   assign resp_any  = |resp_valid_q;

   // Next state: issue, tag shift, response decode, counters and hold/drain FSM
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      opnd_d       = opnd_q;
      tag_v_d      = '0;
      resp_valid_d = '0;
      err_cnt_d    = err_cnt_q;
      tag_v_d[0]   = grant_found;
      tag_id_d[0]  = grant_id;
      for (int unsigned s = 1; s < LAT; s++) begin
         tag_v_d[s]  = tag_v_q[s-1];
         tag_id_d[s] = tag_id_q[s-1];
      end
      if (grant_found) begin
         opnd_d = grant_mat;
         ptr_d  = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
      if (tag_v_q[LAT-1]) resp_valid_d[tag_id_q[LAT-1]] = 1'b1;
      inflight_d = inflight_q + 3'(grant_found) - 3'(tag_v_q[LAT-1]);
      if (resp_any && mi_error && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      case (state_q)
         ST_RUN:   if (hold) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (!hold)                   state_d = ST_RUN;
            else if (inflight_q == 3'd0) state_d = ST_HELD;
         end
         ST_HELD:  if (!hold) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
      idle_d = (state_d == ST_HELD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         ptr_q        <= '0;
         opnd_q       <= '0;
         tag_v_q      <= '0;
         resp_valid_q <= '0;
         inflight_q   <= '0;
         idle_q       <= 1'b0;
         err_cnt_q    <= '0;
         for (int unsigned s = 0; s < LAT; s++) tag_id_q[s] <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         opnd_q       <= opnd_d;
         tag_v_q      <= tag_v_d;
         resp_valid_q <= resp_valid_d;
         inflight_q   <= inflight_d;
         idle_q       <= idle_d;
         err_cnt_q    <= err_cnt_d;
         for (int unsigned s = 0; s < LAT; s++) tag_id_q[s] <= tag_id_d[s];
      end
   end

   assign mi_a       = opnd_q[4*DW-1 -: DW];
   assign mi_b       = opnd_q[3*DW-1 -: DW];
   assign mi_c       = opnd_q[2*DW-1 -: DW];
   assign mi_d       = opnd_q[DW-1:0];
   assign resp_valid = resp_valid_q;
   // Result bus is the matrix_inv output, zeroed when no tag is being returned
   assign resp_mat   = resp_any ? {mi_a_inv, mi_b_inv, mi_c_inv, mi_d_inv} : '0;
   assign resp_err   = resp_any & mi_error;
   assign inflight   = inflight_q;
   assign idle       = idle_q;
   assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_matinv_rr_sched.sv
// Bench for matinv_rr_sched: a behavioural matrix_inv stand-in plus a queue-based
// scoreboard of issued operations checked every cycle, with directed literal checks.
module tb_matinv_rr_sched;
   localparam int N = 4;
   localparam int LAT = 3;
   localparam int DW = 16;
   localparam int M_RUN = 0, M_DRAIN = 1, M_HELD = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*64-1:0] req_mat = '0;
   logic [N-1:0]   req_ready;
   logic           hold = 1'b0;
   logic [DW-1:0]  mi_a, mi_b, mi_c, mi_d;
   logic [DW-1:0]  mi_a_inv, mi_b_inv, mi_c_inv, mi_d_inv;
   logic           mi_error;
   logic [N-1:0]   resp_valid;
   logic [63:0]    resp_mat;
   logic           resp_err;
   logic [2:0]     inflight;
   logic           idle;
   logic [7:0]     err_cnt;

   matinv_rr_sched #(.N_REQ(N), .LAT(LAT), .DW(DW), .IDW(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_mat(req_mat),
      .req_ready(req_ready), .hold(hold),
      .mi_a(mi_a), .mi_b(mi_b), .mi_c(mi_c), .mi_d(mi_d),
      .mi_a_inv(mi_a_inv), .mi_b_inv(mi_b_inv), .mi_c_inv(mi_c_inv), .mi_d_inv(mi_d_inv),
      .mi_error(mi_error), .resp_valid(resp_valid), .resp_mat(resp_mat),
      .resp_err(resp_err), .inflight(inflight), .idle(idle), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Exact Q2.14 inverse: {err, a_inv, b_inv, c_inv, d_inv}; error on singular or overflow
   function automatic logic [64:0] minv(input logic [63:0] m);
      longint a, b, c, d, det, r0, r1, r2, r3;
      a = longint'($signed(m[63:48]));
      b = longint'($signed(m[47:32]));
      c = longint'($signed(m[31:16]));
      d = longint'($signed(m[15:0]));
      det = a * d - b * c;
      if (det == 0) return {1'b1, 64'h0};
      r0 = (d * 268435456) / det;
      r1 = (-b * 268435456) / det;
      r2 = (-c * 268435456) / det;
      r3 = (a * 268435456) / det;
      if (r0 > 32767 || r0 < -32768 || r1 > 32767 || r1 < -32768 ||
          r2 > 32767 || r2 < -32768 || r3 > 32767 || r3 < -32768)
         return {1'b1, 64'h0};
      return {1'b0, r0[15:0], r1[15:0], r2[15:0], r3[15:0]};
   endfunction

   // matrix_inv stand-in: operands registered at edge E0 give a result after edge E0+LAT
   logic [64:0] mpipe [LAT-1];
   logic [64:0] mout = '0;
   always @(posedge clk) begin
      mpipe[0] <= minv({mi_a, mi_b, mi_c, mi_d});
      for (int k = 1; k < LAT - 1; k++) mpipe[k] <= mpipe[k-1];
      mout <= mpipe[LAT-2];
   end
   assign {mi_error, mi_a_inv, mi_b_inv, mi_c_inv, mi_d_inv} = mout;

   typedef struct { int due; int id; logic [64:0] res; } exp_t;
   exp_t q[$];
   int grant_log[$];
   int cyc = 0;
   int ptr_m = 0, mode_m = M_RUN, errc_m = 0;
   int total = 0, bad = 0;
   int n_resp = 0;
   logic [N-1:0] xfer = '0;
   logic [N-1:0] last_rv = '0;
   logic [63:0]  last_mat = '0;
   logic         last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int onehot2id(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Scoreboard: responses due LAT edges after issue, round-robin grants, hold/drain modes
   always @(negedge clk) begin
      logic [N-1:0] erv, g;
      logic [64:0]  eres;
      logic         have;
      int           infl, gid, idx;
      if (reset) begin
         q.delete();
         ptr_m = 0; mode_m = M_RUN; errc_m = 0; xfer = '0;
         chk("rst_resp_valid", 64'(resp_valid), 64'd0);
         chk("rst_inflight", 64'(inflight), 64'd0);
         chk("rst_err_cnt", 64'(err_cnt), 64'd0);
         chk("rst_idle", 64'(idle), 64'd0);
         chk("rst_mi_a", 64'(mi_a), 64'd0);
      end else begin
         erv = '0; have = 1'b0; eres = '0;
         if (q.size() != 0 && q[0].due == cyc) begin
            have = 1'b1; erv[q[0].id] = 1'b1; eres = q[0].res;
            void'(q.pop_front());
         end
         chk("resp_valid", 64'(resp_valid), 64'(erv));
         if (have) begin
            chk("resp_mat", resp_mat, eres[63:0]);
            chk("resp_err", 64'(resp_err), 64'(eres[64]));
         end
         infl = q.size();
         chk("inflight", 64'(inflight), 64'(infl));
         chk("err_cnt", 64'(err_cnt), 64'(errc_m));
         if (have && eres[64] && errc_m < 255) errc_m++;
         chk("idle", 64'(idle), 64'(mode_m == M_HELD));
         if (resp_valid != '0) begin
            n_resp++; last_rv = resp_valid; last_mat = resp_mat; last_err = resp_err;
         end
         g = '0; gid = -1;
         if (mode_m == M_RUN) begin
            for (int k = 0; k < N; k++) begin
               idx = (ptr_m + k) % N;
               if (gid < 0 && req_valid[idx]) gid = idx;
            end
         end
         if (gid >= 0) g[gid] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(g));
         xfer = req_valid & req_ready;
         if (xfer != '0) grant_log.push_back(onehot2id(xfer));
         if (gid >= 0) begin
            q.push_back('{due: cyc + 1 + LAT, id: gid, res: minv(req_mat[gid*64 +: 64])});
            ptr_m = (gid + 1) % N;
         end
         case (mode_m)
            M_RUN:   if (hold) mode_m = M_DRAIN;
            M_DRAIN: if (!hold) mode_m = M_RUN; else if (infl == 0) mode_m = M_HELD;
            default: if (!hold) mode_m = M_RUN;
         endcase
      end
   end

   // Raise one request, wait (bounded) for its grant, then drop valid after the issue edge
   task automatic issue1(input int id, input logic [63:0] m);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      req_mat[id*64 +: 64] = m;
      req_valid[id] = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      chk("grant_wait", 64'(got), 64'd1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   function automatic logic [63:0] rand_mat();
      logic [15:0] a, b, c, d;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      case ($urandom_range(0, 2))
         0: return {a, b, a, b};
         1: return {16'h4000 + {8'h0, a[7:0]}, {8'h0, b[7:0]}, {8'h0, c[7:0]}, 16'h3000 + {8'h0, d[7:0]}};
         default: return {a, b, c, d};
      endcase
   endfunction

   initial begin
      int n0, s0, last_r, first_i;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Identity from requester 0
      issue1(0, 64'h4000_0000_0000_4000);
      chk("t1_mi_a", 64'(mi_a), 64'h4000);
      repeat (LAT + 2) @(negedge clk);
      chk("t1_valid", 64'(last_rv), 64'b0001);
      chk("t1_mat", last_mat, 64'h4000_0000_0000_4000);
      chk("t1_err", 64'(last_err), 64'd0);

      // Upper-triangular from requester 2
      issue1(2, 64'h4000_2000_0000_4000);
      repeat (LAT + 2) @(negedge clk);
      chk("t2_valid", 64'(last_rv), 64'b0100);
      chk("t2_mat", last_mat, 64'h4000_E000_0000_4000);
      chk("t2_err", 64'(last_err), 64'd0);

      // Singular from requester 1
      issue1(1, 64'h4000_4000_4000_4000);
      repeat (LAT + 2) @(negedge clk);
      chk("t3_valid", 64'(last_rv), 64'b0010);
      chk("t3_err", 64'(last_err), 64'd1);
      chk("t3_err_cnt", 64'(err_cnt), 64'd1);

      // Async reset one cycle after an issue discards it
      n0 = n_resp;
      issue1(3, 64'h4000_0000_0000_4000);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (LAT + 3) @(negedge clk);
      chk("t6_no_resp", 64'(n_resp - n0), 64'd0);
      chk("t6_inflight", 64'(inflight), 64'd0);
      chk("t6_err_cnt", 64'(err_cnt), 64'd0);

      // All four requesters valid for 8 cycles
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) req_mat[i*64 +: 64] = {16'h4000, 16'(i * 16'h100), 16'h0, 16'h4000};
      s0 = grant_log.size();
      req_valid = '1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("t4_inflight", 64'(inflight), 64'd3);
      repeat (3) @(posedge clk);
      #1 req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         if (grant_log.size() > s0 + k) chk("t4_order", 64'(grant_log[s0+k]), 64'(k % 4));
         else chk("t4_order_missing", 64'(grant_log.size()), 64'(s0 + k + 1));
      end
      repeat (LAT + 2) @(negedge clk);

      // Hold with two operations in flight, then resume from the saved pointer
      @(posedge clk); #1 req_valid = 4'b0011;
      @(posedge clk); #1 req_valid = req_valid & ~xfer;
      @(posedge clk); #1 req_valid = req_valid & ~xfer; hold = 1'b1;
      @(posedge clk); #1 req_valid = 4'b1001;
      @(negedge clk);
      chk("t5_ready_off", 64'(req_ready), 64'd0);
      chk("t5_inflight", 64'(inflight), 64'd2);
      last_r = -1; first_i = -1;
      for (int k = 0; k < 10; k++) begin
         if (resp_valid != '0) last_r = cyc;
         if (idle && first_i < 0) first_i = cyc;
         @(negedge clk);
      end
      chk("t5_idle_after_last", 64'(first_i - last_r), 64'd1);
      @(posedge clk); #1 hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5_resume_ptr", 64'(req_ready), 64'b1000);
      repeat (4) begin @(posedge clk); #1 req_valid = req_valid & ~xfer; end

      // Randomized traffic with occasional hold toggles
      repeat (800) begin
         @(posedge clk); #1;
         req_valid = req_valid & ~xfer;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 99) < 60) begin
               req_mat[i*64 +: 64] = rand_mat();
               req_valid[i] = 1'b1;
            end
         end
         if ($urandom_range(0, 99) < 4) hold = ~hold;
      end
      hold = 1'b0;
      repeat (20) begin @(posedge clk); #1 req_valid = req_valid & ~xfer; end
      repeat (LAT + 3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
